dcache_wt: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache between the memory stage of the 5-stage RISC-V pipeline and the backing data memory. It serves loads and stores on the memory-stage ALU address with RV32 byte/half/word sizing, including sign extension. On a miss it raises `stall` to the hazard unit and refills a 4-word line over a req/ack memory port. Stores always write through, and are held by `stall` until the backing memory acknowledges.

---
 rtl/dcache_wt_pkg.sv | 30 +++
 rtl/dcache_wt_if.sv | 24 ++
 rtl/dcache_wt_lane_align.sv | 50 +++++
 rtl/dcache_wt.sv | 209 ++++++++++++++++++++
 tb/tb_dcache_wt.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_wt_pkg.sv
// Shared types and constants for the write-through data cache: FSM state
// encoding, RV32 load/store funct3 codes and default address-split widths.
package dcache_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Load size codes
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store size codes
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Address split for the default geometry: 16-byte lines, 64 sets.
  localparam int DC_SETS  = 64;
  localparam int DC_WORDS = 4;
  localparam int OFF_W    = 4;                      // byte + word offset
  localparam int IDX_W    = $clog2(DC_SETS);
  localparam int TAG_W    = 32 - OFF_W - IDX_W;

endpackage

// File: rtl/dcache_wt_if.sv
// Backing-memory req/ack port of the data cache. The cache is the master;
// the memory (or bench model) is the slave.
interface dcache_wt_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_wt_lane_align.sv
// Combinational byte-lane steering: load extraction with sign/zero extension
// from a cached word, and store strobe + lane-shifted data for write-through.
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  boff_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wd_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_wstrb_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load: pick byte/half by low address bits; misaligned low bits are ignored.
  always_comb begin
    ld_byte = rword_i[{boff_i, 3'b000} +: 8];
    ld_half = boff_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (funct3_i)
      LB:      ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      LBU:     ld_data_o = {24'b0, ld_byte};
      LH:      ld_data_o = {{16{ld_half[15]}}, ld_half};
      LHU:     ld_data_o = {16'b0, ld_half};
      LW:      ld_data_o = rword_i;
      default: ld_data_o = rword_i;
    endcase
  end

  // Store: right-aligned data moved into its byte lanes with matching strobes.
  always_comb begin
    case (funct3_i)
      SB: begin
        st_wstrb_o = 4'b0001 << boff_i;
        st_wdata_o = {24'b0, wd_i[7:0]} << {boff_i, 3'b000};
      end
      SH: begin
        st_wstrb_o = boff_i[1] ? 4'b1100 : 4'b0011;
        st_wdata_o = boff_i[1] ? {wd_i[15:0], 16'b0} : {16'b0, wd_i[15:0]};
      end
      default: begin
        st_wstrb_o = 4'b1111;
        st_wdata_o = wd_i;
      end
    endcase
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM
// stage. Load misses refill a 4-word line; every store is written through
// and merged into the line only if it is already present.
// Optional DCACHE_STATS_EN adds hit_count / miss_count outputs.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SETS           = DC_SETS,
  parameter int WORDS_PER_LINE = DC_WORDS
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               funct3,
  input  logic [ADDRESS_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0]    wd_data,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     cache_hit,
  output logic                     stall,
  dcache_wt_if.master              mem
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDRESS_WIDTH - OFF_W - IW;

  state_e state_q, state_d;

  logic [SETS-1:0]       valid_q;
  logic [TW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

  // Word address only; bits [3:2] double as the refill beat counter.
  logic [ADDRESS_WIDTH-1:2] mem_addr_q, mem_addr_d;
  logic                     mem_req_q, mem_req_d;
  logic                     mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [3:0]               mem_wstrb_q, mem_wstrb_d;

  logic stall_c, miss_start, fill_done, beat_ack, wr_ack, ack;

  // Lookup side (CPU address)
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tag;
  logic [1:0]    r_word;
  logic          line_hit, hit;

  assign r_idx    = daddr[OFF_W +: IW];
  assign r_tag    = daddr[ADDRESS_WIDTH-1 -: TW];
  assign r_word   = daddr[3:2];
  assign line_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  assign hit      = !rst && req_valid && line_hit;

  // Fill/merge side (registered memory address)
  logic [IW-1:0] m_idx;
  logic [TW-1:0] m_tag;
  logic [1:0]    m_word;
  logic          wr_line_hit;

  assign m_idx       = mem_addr_q[OFF_W +: IW];
  assign m_tag       = mem_addr_q[ADDRESS_WIDTH-1 -: TW];
  assign m_word      = mem_addr_q[3:2];
  assign wr_line_hit = valid_q[m_idx] && (tag_q[m_idx] == m_tag);

  assign ack = mem.mem_ack && mem_req_q;

  logic [DATA_WIDTH-1:0] ld_data, st_wdata;
  logic [3:0]            st_wstrb;

  dcache_lane_align u_align (
    .funct3_i   (funct3),
    .boff_i     (daddr[1:0]),
    .rword_i    (data_q[r_idx][r_word]),
    .wd_i       (wd_data),
    .ld_data_o  (ld_data),
    .st_wdata_o (st_wdata),
    .st_wstrb_o (st_wstrb)
  );

  assign rd_data   = hit ? ld_data : '0;
  assign cache_hit = hit;
  assign stall     = !rst && stall_c;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = {mem_addr_q, 2'b00};
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

  // Next state, stall and next memory-port register values.
  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    miss_start  = 1'b0;
    fill_done   = 1'b0;
    beat_ack    = 1'b0;
    wr_ack      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = req_valid && (!line_hit || req_we);
        if (req_valid && req_we) begin
          state_d     = S_WRITE;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = daddr[ADDRESS_WIDTH-1:2];
          mem_wdata_d = st_wdata;
          mem_wstrb_d = st_wstrb;
        end else if (req_valid && !line_hit) begin
          state_d     = S_REFILL;
          miss_start  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {daddr[ADDRESS_WIDTH-1:4], 2'b00};
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
      S_REFILL: begin
        stall_c = 1'b1;
        if (ack) begin
          beat_ack = 1'b1;
          if (m_word == 2'd3) begin
            fill_done = 1'b1;
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end else begin
            mem_addr_d = {mem_addr_q[ADDRESS_WIDTH-1:4], m_word + 2'd1};
          end
        end
      end
      S_WRITE: begin
        stall_c = 1'b1;
        if (ack) begin
          wr_ack    = 1'b1;
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: begin
        // S_DONE: one free cycle so the held store retires.
        state_d = S_IDLE;
      end
    endcase
  end

  // State and memory-port registers; reset drops the request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  // Valid bits: the victim line is invalidated when its refill starts, so a
  // partially overwritten line can never be hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             valid_q <= '0;
    else if (fill_done)  valid_q[m_idx] <= 1'b1;
    else if (miss_start) valid_q[r_idx] <= 1'b0;
  end

  // Data/tag arrays (not reset): refill beats and write-through merges.
  always_ff @(posedge clk) begin
    if (beat_ack) data_q[m_idx][m_word] <= mem.mem_rdata;
    if (fill_done) tag_q[m_idx] <= m_tag;
    if (wr_ack && wr_line_hit) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb_q[b]) data_q[m_idx][m_word][8*b +: 8] <= mem_wdata_q[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == S_IDLE && hit && !req_we) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: zero-wait memory model, table of load/store
// vectors with hand-computed results, plus hand-written multi-cycle cases.
module tb_dcache_wt;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] daddr, wd_data, rd_data;
  logic        cache_hit, stall;
  logic        ack_en;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_wt_if #(.AW(32), .DW(32)) mif ();

  dcache_wt dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .daddr     (daddr),
    .wd_data   (wd_data),
    .rd_data   (rd_data),
    .cache_hit (cache_hit),
    .stall     (stall),
    .mem       (mif)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // Backing memory: 16 KiB, word = 0xA5000000 ^ byte address, 0x104 = 0x000080FF.
  logic [31:0] mem [0:4095];
  logic        mem_ready = 1'b0;

  assign mif.mem_ack   = ack_en & mif.mem_req;
  assign mif.mem_rdata = mem[mif.mem_addr[13:2]];

  // Memory init on the first edge, then byte-strobed write-through updates.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 ^ (i << 2);
      mem[32'h104 >> 2] <= 32'h0000_80FF;
      mem_ready <= 1'b1;
    end else if (mif.mem_req && mif.mem_we && mif.mem_ack) begin
      for (int b = 0; b < 4; b++)
        if (mif.mem_wstrb[b]) mem[mif.mem_addr[13:2]][8*b +: 8] <= mif.mem_wdata[8*b +: 8];
    end
  end

  // Beat log: one entry per acked cycle.
  logic [31:0] rd_beats [$];
  logic [31:0] wr_addr  [$];
  logic [31:0] wr_data  [$];
  logic [3:0]  wr_strb  [$];

  always @(negedge clk) begin
    if (mif.mem_req && mif.mem_ack) begin
      if (mif.mem_we) begin
        wr_addr.push_back(mif.mem_addr);
        wr_data.push_back(mif.mem_wdata);
        wr_strb.push_back(mif.mem_wstrb);
      end else begin
        rd_beats.push_back(mif.mem_addr);
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one access (called just after a rising edge); hold it until stall
  // clears, return the result sampled on that falling edge.
  task automatic access(input logic [2:0] f3, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, output logic [31:0] rd, output logic hit,
                        output int stalls, output logic req_at_done);
    req_valid = 1'b1; req_we = we; funct3 = f3; daddr = a; wd_data = wd;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    rd = rd_data; hit = cache_hit; req_at_done = mif.mem_req;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_stalls;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] rd;
    logic        h, mr;
    int          st, n0, w0;

    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        h, mr;
    int          st, n0, w0;

    vecs[0]  = '{LB,    32'h104, 1'b0, 32'h0,        32'hFFFF_FFFF, 0};
    vecs[1]  = '{LBU,   32'h105, 1'b0, 32'h0,        32'h0000_0080, 0};
    vecs[2]  = '{LH,    32'h104, 1'b0, 32'h0,        32'hFFFF_80FF, 0};
    vecs[3]  = '{LHU,   32'h104, 1'b0, 32'h0,        32'h0000_80FF, 0};
    vecs[4]  = '{LW,    32'h104, 1'b0, 32'h0,        32'h0000_80FF, 0};
    vecs[5]  = '{LH,    32'h106, 1'b0, 32'h0,        32'h0000_0000, 0};
    vecs[6]  = '{LW,    32'h106, 1'b0, 32'h0,        32'h0000_80FF, 0};
    vecs[7]  = '{3'b011,32'h104, 1'b0, 32'h0,        32'h0000_80FF, 0};
    vecs[8]  = '{LB,    32'h10B, 1'b0, 32'h0,        32'hFFFF_FFA5, 0};
    vecs[9]  = '{LHU,   32'h10A, 1'b0, 32'h0,        32'h0000_A500, 0};
    vecs[10] = '{SH,    32'h10A, 1'b1, 32'h1234_5678,32'h0,         2};
    vecs[11] = '{LW,    32'h108, 1'b0, 32'h0,        32'h5678_0108, 0};
    vecs[12] = '{SW,    32'h10C, 1'b1, 32'hDEAD_BEEF,32'h0,         2};
    vecs[13] = '{LW,    32'h10C, 1'b0, 32'h0,        32'hDEAD_BEEF, 0};
    vecs[14] = '{LBU,   32'h10E, 1'b0, 32'h0,        32'h0000_00AD, 0};
    vecs[15] = '{LH,    32'h10E, 1'b0, 32'h0,        32'hFFFF_DEAD, 0};

    // Reset: outputs quiet even with a missing load presented.
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; funct3 = LW; daddr = 32'h100;
    wd_data = 32'h0; ack_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall",     32'(stall),         32'h0);
    chk("reset mem_req",   32'(mif.mem_req),   32'h0);
    chk("reset mem_we",    32'(mif.mem_we),    32'h0);
    chk("reset mem_addr",  mif.mem_addr,       32'h0);
    chk("reset mem_wdata", mif.mem_wdata,      32'h0);
    chk("reset mem_wstrb", 32'(mif.mem_wstrb), 32'h0);
    chk("reset rd_data",   rd_data,            32'h0);
    chk("reset cache_hit", 32'(cache_hit),     32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;

    // LW 0x100 cold miss: four consecutive beats, then hit.
    n0 = rd_beats.size();
    access(LW, 32'h100, 1'b0, 32'h0, rd, h, st, mr);
    chk("lw100 stall cycles", 32'(st), 32'd5);
    chk("lw100 rd_data",      rd,      32'hA500_0100);
    chk("lw100 cache_hit",    32'(h),  32'h1);
    chk("lw100 beat count",   32'(rd_beats.size() - n0), 32'd4);
    if (rd_beats.size() - n0 >= 4)
      for (int k = 0; k < 4; k++)
        chk($sformatf("lw100 beat%0d addr", k), rd_beats[n0+k], 32'h100 + 32'(4*k));

    // Table of hits and store-hit merges into the 0x100 line.
    for (int i = 0; i < 16; i++) begin
      access(vecs[i].f3, vecs[i].addr, vecs[i].we, vecs[i].wd, rd, h, st, mr);
      chk($sformatf("vec%0d stall cycles", i), 32'(st), 32'(vecs[i].exp_stalls));
      if (!vecs[i].we) begin
        chk($sformatf("vec%0d rd_data", i), rd, vecs[i].exp_rd);
        chk($sformatf("vec%0d cache_hit", i), 32'(h), 32'h1);
      end
    end

    // SB hit 0x106: lane 2 strobe, one DONE cycle, merged line.
    w0 = wr_addr.size();
    access(SB, 32'h106, 1'b1, 32'h0000_00AA, rd, h, st, mr);
    chk("sb106 stall cycles", 32'(st), 32'd2);
    chk("sb106 mem_req in DONE", 32'(mr), 32'h0);
    chk("sb106 write beats", 32'(wr_addr.size() - w0), 32'd1);
    if (wr_addr.size() > w0) begin
      chk("sb106 mem_addr",  wr_addr[w0],       32'h104);
      chk("sb106 mem_wstrb", 32'(wr_strb[w0]),  32'h4);
      chk("sb106 mem_wdata", wr_data[w0],       32'h00AA_0000);
    end
    access(LW, 32'h104, 1'b0, 32'h0, rd, h, st, mr);
    chk("lw104 after sb stall cycles", 32'(st), 32'd0);
    chk("lw104 after sb rd_data", rd, 32'h00AA_80FF);

    // SW miss 0x2000: single write beat, no allocation.
    n0 = rd_beats.size(); w0 = wr_addr.size();
    access(SW, 32'h2000, 1'b1, 32'h1122_3344, rd, h, st, mr);
    chk("sw2000 stall cycles", 32'(st), 32'd2);
    chk("sw2000 write beats",  32'(wr_addr.size() - w0), 32'd1);
    chk("sw2000 read beats",   32'(rd_beats.size() - n0), 32'd0);
    access(LW, 32'h2000, 1'b0, 32'h0, rd, h, st, mr);
    chk("lw2000 stall cycles (miss)", 32'(st), 32'd5);
    chk("lw2000 rd_data", rd, 32'h1122_3344);

    // Conflict: 0x100 / 0x500 / 0x100 share an index, all miss after reset.
    rst = 1'b1;
    @(negedge clk);
    chk("reset2 mem_req", 32'(mif.mem_req), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(LW, 32'h100, 1'b0, 32'h0, rd, h, st, mr);
    chk("conflict a stall cycles", 32'(st), 32'd5);
    chk("conflict a rd_data", rd, 32'hA500_0100);
    access(LW, 32'h500, 1'b0, 32'h0, rd, h, st, mr);
    chk("conflict b stall cycles", 32'(st), 32'd5);
    chk("conflict b rd_data", rd, 32'hA500_0500);
    access(LW, 32'h100, 1'b0, 32'h0, rd, h, st, mr);
    chk("conflict c stall cycles", 32'(st), 32'd5);
    chk("conflict c rd_data", rd, 32'hA500_0100);

    // Reset during refill beat 2 of LW 0x900.
    req_valid = 1'b1; req_we = 1'b0; funct3 = LW; daddr = 32'h900;
    repeat (3) @(posedge clk);
    #2;
    chk("midfill mem_req before reset", 32'(mif.mem_req), 32'h1);
    chk("midfill beat2 mem_addr", mif.mem_addr, 32'h908);
    rst = 1'b1;
    #1;
    chk("midfill mem_req async drop", 32'(mif.mem_req), 32'h0);
    chk("midfill stall async drop",   32'(stall),       32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    n0 = rd_beats.size();
    access(LW, 32'h900, 1'b0, 32'h0, rd, h, st, mr);
    chk("after midfill stall cycles", 32'(st), 32'd5);
    chk("after midfill beat count", 32'(rd_beats.size() - n0), 32'd4);
    chk("after midfill rd_data", rd, 32'hA500_0900);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
